// File: rtl/outpkt_framer.sv
// outpkt_framer: byte-serial transmit framer emitting a versioned header, header checksum, payload and payload checksum
//
// Optional feature macro: OUTPKT_CHECKSUM_EN
//   defined     -> HCSUM/DCSUM carry ~(sum of little-endian 32-bit words), LSB byte first
//   not defined -> no accumulator; HCSUM/DCSUM still emit 4 bytes each, all 0x00
//
// Ports:
//   CLK          clock
//   rst_n        asynchronous active-low reset
//   start        request a new packet, sampled while start_ready=1
//   start_ready  framer idle and accepting start
//   pkt_type     packet type, latched on accepted start
//   pkt_id       packet id, latched on accepted start
//   pkt_len      payload byte count, latched on accepted start
//   err_start    sticky flag: start seen with illegal type or length
//   din          payload byte
//   din_valid    din holds a byte
//   din_ready    payload byte is consumed this cycle when din_valid=1
//   dout         framed output byte (registered)
//   dout_valid   dout holds a byte (registered)
//   dout_ready   sink takes dout this cycle
module outpkt_framer #(
   parameter int VERSION = 2,
   parameter int PKT_MAX_LEN = 65536,
   parameter int PKT_MAX_TYPE = 3,
   localparam int PKT_LEN_MSB = $clog2(PKT_MAX_LEN + 1) - 1,
   localparam int PKT_TYPE_MSB = $clog2(PKT_MAX_TYPE + 1) - 1
) (
   input  logic                  CLK,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  start_ready,
   input  logic [PKT_TYPE_MSB:0] pkt_type,
   input  logic [15:0]           pkt_id,
   input  logic [23:0]           pkt_len,
   output logic                  err_start,
   input  logic [7:0]            din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [7:0]            dout,
   output logic                  dout_valid,
   input  logic                  dout_ready
);
   localparam int CW = PKT_LEN_MSB + 1;
   typedef enum logic [2:0] {IDLE, HDR, HCSUM, DATA, DCSUM} state_t;
   state_t                r_state, w_state_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt, r_len;
   logic [PKT_TYPE_MSB:0] r_type;
   logic [15:0]           r_id;
   logic [7:0]            r_dout, w_byte, w_hdr_byte, w_csum_byte;
   logic                  r_dout_valid, r_err, w_load, w_free, w_xfer, w_legal;
   logic [23:0]           w_len24;
   logic [31:0]           w_csum;
   assign w_xfer      = r_dout_valid & dout_ready;
   assign w_free      = ~r_dout_valid | dout_ready;
   assign w_legal     = (pkt_type != '0) && (32'(pkt_type) <= PKT_MAX_TYPE) &&
                        (pkt_len != '0) && (32'(pkt_len) <= PKT_MAX_LEN);
   assign w_len24     = 24'(r_len);
   assign w_csum_byte = w_csum[{r_cnt[1:0], 3'b000} +: 8];
   assign start_ready = r_state == IDLE;
   assign din_ready   = (r_state == DATA) & w_free;
   assign dout        = r_dout;
   assign dout_valid  = r_dout_valid;
   assign err_start   = r_err;
`ifdef OUTPKT_CHECKSUM_EN
   logic [31:0] r_acc;
   assign w_csum = ~r_acc;
   // Only freshly loaded header/payload bytes are summed; checksum bytes and stalled repeats are not.
   // The accumulator is cleared entering DATA and again when the packet completes.
   always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n)
         r_acc <= '0;
      else if ((r_state == HCSUM && w_state_nxt == DATA) || (r_state == DCSUM && w_state_nxt == IDLE))
         r_acc <= '0;
      else if (w_load && r_state != HCSUM && r_state != DCSUM)
         r_acc <= r_acc + (32'(w_byte) << {r_cnt[1:0], 3'b000});
`else
   assign w_csum = '0;
`endif
   always_comb begin
      case (r_cnt[3:0])
         4'd0:    w_hdr_byte = 8'(VERSION);
         4'd1:    w_hdr_byte = 8'(r_type);
         4'd4:    w_hdr_byte = w_len24[7:0];
         4'd5:    w_hdr_byte = w_len24[15:8];
         4'd6:    w_hdr_byte = w_len24[23:16];
         4'd8:    w_hdr_byte = r_id[7:0];
         4'd9:    w_hdr_byte = r_id[15:8];
         default: w_hdr_byte = 8'h00;
      endcase
   end
   always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   // r_cnt is the index of the next byte to load within the current phase.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_byte      = 8'h00;
      case (r_state)
         IDLE: if (start && w_legal) begin
            w_state_nxt = HDR;
            w_load      = 1'b1;
            w_byte      = 8'(VERSION);
            w_cnt_nxt   = CW'(1);
         end
         HDR: if (w_free) begin
            w_load      = 1'b1;
            w_byte      = w_hdr_byte;
            w_state_nxt = r_cnt == CW'(9) ? HCSUM : HDR;
            w_cnt_nxt   = r_cnt == CW'(9) ? '0 : r_cnt + 1'b1;
         end
         HCSUM: if (w_free) begin
            w_load      = 1'b1;
            w_byte      = w_csum_byte;
            w_state_nxt = r_cnt == CW'(3) ? DATA : HCSUM;
            w_cnt_nxt   = r_cnt == CW'(3) ? '0 : r_cnt + 1'b1;
         end
         DATA: if (w_free && din_valid) begin
            w_load      = 1'b1;
            w_byte      = din;
            w_state_nxt = r_cnt == r_len - 1'b1 ? DCSUM : DATA;
            w_cnt_nxt   = r_cnt == r_len - 1'b1 ? '0 : r_cnt + 1'b1;
         end
         DCSUM:
            // After the fourth byte is loaded, wait for it to leave before going idle.
            if (r_cnt == CW'(4)) begin
               w_state_nxt = w_xfer ? IDLE : DCSUM;
               w_cnt_nxt   = w_xfer ? '0 : r_cnt;
            end else if (w_free) begin
               w_load    = 1'b1;
               w_byte    = w_csum_byte;
               w_cnt_nxt = r_cnt + 1'b1;
            end
         default: w_state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n) begin
         r_cnt        <= '0;
         r_len        <= '0;
         r_type       <= '0;
         r_id         <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (start_ready && start && w_legal) begin
            r_len  <= pkt_len[PKT_LEN_MSB:0];
            r_type <= pkt_type;
            r_id   <= pkt_id;
         end
         if (start_ready && start && !w_legal)
            r_err <= 1'b1;
         if (w_load) begin
            r_dout       <= w_byte;
            r_dout_valid <= 1'b1;
         end else if (w_xfer)
            r_dout_valid <= 1'b0;
      end
endmodule
